id_ex_reg: RTL and testbench
============================

// Module: id_ex_reg
// PURPOSE
//  ID/EX pipeline register of the five-stage core, with integrated load-use hazard detection.
//  Captures decoded control and operands from ID and presents them to EX (ALU control decode, ALU, forwarding).
//  Inserts a bubble on a load-use hazard and raises hazard_stall so that PC and IF/ID hold.
// PARAMETERS
//  XLEN        32  datapath width (pc, operands, immediate)
//  REG_ADDR_W  5   register-index width
// PORTS
//  clk            in   1              rising-edge clock, sole clock
//  rst            in   1              synchronous reset, active-high
//  hold_in        in   1              downstream (MEM) stall: freeze ID/EX contents
//  flush_in       in   1              EX branch/jump redirect: kill the instruction entering EX
//  id_valid       in   1              ID holds a real instruction
//  id_pc, id_rs1_data, id_rs2_data, id_imm   in  XLEN each   ID datapath values
//  id_rs1, id_rs2, id_rd    in  REG_ADDR_W each              register indices
//  id_uses_rs1, id_uses_rs2 in  1 each                       instruction reads rs1/rs2
//  id_alu_op      in   `ALU_OP_WIDTH  00=add(ld/st), x1=branch-sub, 10=R/I-type
//  id_funct3      in   `FUNCT3_WIDTH
//  id_funct7      in   `FUNCT7_WIDTH
//  id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg, id_branch  in  1 each
//  ex_*           out  (same widths)  registered copy of every id_* input above, incl. ex_valid
//  hazard_stall   out  1              combinational: hold PC and IF/ID this cycle
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high. All updates happen on posedge clk.
//  - Reset: every ex_* output is 0 (ex_alu_op=2'b00, ex_valid=0). hazard_stall is 0 while ex_valid=0.
//  - Hazard (combinational): haz = ex_valid & ex_mem_read & (ex_rd!=0) & id_valid &
//      ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
//  - hazard_stall = haz & ~flush_in. Flush kills the ID instruction, so no stall is needed.
//  - Per-edge update priority (first match wins):
//      1 rst      -> all cleared
//      2 flush_in -> bubble
//      3 hold_in  -> all ex_* keep their values (hazard_stall still follows haz)
//      4 haz      -> bubble
//      5 else     -> load all id_* into ex_*; ex_valid<=id_valid
//  - Bubble: ex_valid=0; ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_mem_to_reg,
//    ex_alu_src = 0; ex_alu_op=2'b00; funct/data/index fields = 0.
//    A bubble is therefore a harmless ADD with no writeback.
//  - Latency: exactly 1 cycle ID->EX when neither stall nor flush is active. No internal FSM beyond the register.
//  - A load-use produces exactly one bubble. Next cycle the load is in MEM, haz drops, and the dependent instruction loads.
//  - Simultaneous hold_in & haz: the register holds (the load stays in EX) and stall persists; the bubble is inserted
//    on the first edge with hold_in=0.
//  - id_valid=0 with no stall/flush: loads normally, but ex_valid=0 and all control bits are forced to 0.
//  - rst asserted mid-stall: the next edge clears the register; hazard_stall drops in the same cycle because ex_valid=0.
//  - Writes to x0 never cause a hazard (ex_rd!=0 term).
// CONFIGURATION
//  ID_EX_PERF_EN defined: adds outputs bubble_cnt[31:0] and flush_cnt[31:0].
//    - bubble_cnt increments on each edge that takes priority 4.
//    - flush_cnt increments on each edge with flush_in & ~rst.
//    - Both counters are cleared by rst and wrap 0xFFFFFFFF->0.
//  ID_EX_PERF_EN undefined: no counters, no extra ports, no extra flops.
// TESTING
//  1 rst=1 for 2 cycles with random id_* -> all ex_*=0, hazard_stall=0.
//  2 ADD (rd=5, reg_write=1, alu_op=10), no stall -> next cycle ex_rd=5, ex_reg_write=1, ex_alu_op=2'b10, ex_valid=1.
//  3 LW x6 in EX, then ID ADD with rs2=6 -> hazard_stall=1 for 1 cycle, then ex_valid=0 bubble,
//    then ADD appears in EX; bubble_cnt=1 if PERF.
//  4 LW x0 in EX, ID reads rs1=0 -> hazard_stall=0 and no bubble.
//  5 flush_in=1 with hold_in=1 and haz=1 -> hazard_stall=0; next ex_valid=0, ex_mem_write=0; flush_cnt+1.
//  6 hold_in=1 for 3 cycles with changing id_* -> ex_* constant; on release, the id_* values present that cycle load.

Source files
------------

// File: rtl/id_ex_reg.sv
// ----------------------------------------------------------------------------
// id_ex_reg -- ID/EX pipeline register with integrated load-use hazard detect.
//
// Captures the decoded instruction from ID and presents it to EX one cycle
// later. When the instruction in EX is a load whose destination is read by the
// instruction in ID, a bubble (a harmless ADD with no writeback) is inserted
// and hazard_stall tells PC and IF/ID to hold for that cycle.
//
// Ports
//   clk, rst            rising-edge clock; synchronous active-high reset
//   hold_in             MEM stall: freeze the whole register
//   flush_in            EX redirect: kill the instruction entering EX
//   id_*                decoded instruction from ID (id_valid qualifies it)
//   ex_*                registered copy of every id_* input
//   hazard_stall        combinational load-use stall request to PC / IF/ID
//
// Optional build macro
//   ID_EX_PERF_EN       adds bubble_cnt / flush_cnt 32-bit event counters
// ----------------------------------------------------------------------------
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 2
`endif
`ifndef FUNCT3_WIDTH
`define FUNCT3_WIDTH 3
`endif
`ifndef FUNCT7_WIDTH
`define FUNCT7_WIDTH 7
`endif

module id_ex_reg #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     hold_in,
    input  logic                     flush_in,
    input  logic                     id_valid,
    input  logic [XLEN-1:0]          id_pc,
    input  logic [XLEN-1:0]          id_rs1_data,
    input  logic [XLEN-1:0]          id_rs2_data,
    input  logic [XLEN-1:0]          id_imm,
    input  logic [REG_ADDR_W-1:0]    id_rs1,
    input  logic [REG_ADDR_W-1:0]    id_rs2,
    input  logic [REG_ADDR_W-1:0]    id_rd,
    input  logic                     id_uses_rs1,
    input  logic                     id_uses_rs2,
    input  logic [`ALU_OP_WIDTH-1:0] id_alu_op,
    input  logic [`FUNCT3_WIDTH-1:0] id_funct3,
    input  logic [`FUNCT7_WIDTH-1:0] id_funct7,
    input  logic                     id_alu_src,
    input  logic                     id_mem_read,
    input  logic                     id_mem_write,
    input  logic                     id_reg_write,
    input  logic                     id_mem_to_reg,
    input  logic                     id_branch,
    output logic                     ex_valid,
    output logic [XLEN-1:0]          ex_pc,
    output logic [XLEN-1:0]          ex_rs1_data,
    output logic [XLEN-1:0]          ex_rs2_data,
    output logic [XLEN-1:0]          ex_imm,
    output logic [REG_ADDR_W-1:0]    ex_rs1,
    output logic [REG_ADDR_W-1:0]    ex_rs2,
    output logic [REG_ADDR_W-1:0]    ex_rd,
    output logic                     ex_uses_rs1,
    output logic                     ex_uses_rs2,
    output logic [`ALU_OP_WIDTH-1:0] ex_alu_op,
    output logic [`FUNCT3_WIDTH-1:0] ex_funct3,
    output logic [`FUNCT7_WIDTH-1:0] ex_funct7,
    output logic                     ex_alu_src,
    output logic                     ex_mem_read,
    output logic                     ex_mem_write,
    output logic                     ex_reg_write,
    output logic                     ex_mem_to_reg,
    output logic                     ex_branch,
`ifdef ID_EX_PERF_EN
    output logic [31:0]              bubble_cnt,
    output logic [31:0]              flush_cnt,
`endif
    output logic                     hazard_stall
);

    typedef struct packed {
        logic                     valid;
        logic [XLEN-1:0]          pc;
        logic [XLEN-1:0]          rs1_data;
        logic [XLEN-1:0]          rs2_data;
        logic [XLEN-1:0]          imm;
        logic [REG_ADDR_W-1:0]    rs1;
        logic [REG_ADDR_W-1:0]    rs2;
        logic [REG_ADDR_W-1:0]    rd;
        logic                     uses_rs1;
        logic                     uses_rs2;
        logic [`ALU_OP_WIDTH-1:0] alu_op;
        logic [`FUNCT3_WIDTH-1:0] funct3;
        logic [`FUNCT7_WIDTH-1:0] funct7;
        logic                     alu_src;
        logic                     mem_read;
        logic                     mem_write;
        logic                     reg_write;
        logic                     mem_to_reg;
        logic                     branch;
    } id_ex_t;

    id_ex_t id_pkt;
    id_ex_t ex_d, ex_q;
    logic   haz;

    // Load-use: EX holds a live load to a non-x0 register that ID reads.
    assign haz = ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) & id_valid &
                 ((id_uses_rs1 & (id_rs1 == ex_q.rd)) |
                  (id_uses_rs2 & (id_rs2 == ex_q.rd)));

    // A flushed ID instruction never reaches EX, so it cannot need a stall.
    assign hazard_stall = haz & ~flush_in;

    always_comb begin
        id_pkt            = '0;
        id_pkt.valid      = id_valid;
        id_pkt.pc         = id_pc;
        id_pkt.rs1_data   = id_rs1_data;
        id_pkt.rs2_data   = id_rs2_data;
        id_pkt.imm        = id_imm;
        id_pkt.rs1        = id_rs1;
        id_pkt.rs2        = id_rs2;
        id_pkt.rd         = id_rd;
        id_pkt.uses_rs1   = id_uses_rs1;
        id_pkt.uses_rs2   = id_uses_rs2;
        id_pkt.funct3     = id_funct3;
        id_pkt.funct7     = id_funct7;
        // Control bits only survive for a real instruction; an invalid slot
        // travels as an ADD with no side effects.
        if (id_valid) begin
            id_pkt.alu_op     = id_alu_op;
            id_pkt.alu_src    = id_alu_src;
            id_pkt.mem_read   = id_mem_read;
            id_pkt.mem_write  = id_mem_write;
            id_pkt.reg_write  = id_reg_write;
            id_pkt.mem_to_reg = id_mem_to_reg;
            id_pkt.branch     = id_branch;
        end
    end

    // Flush beats hold: the killed instruction must not linger in EX even
    // while MEM is stalled. Hold beats the hazard bubble so the load stays put.
    always_comb begin
        ex_d = ex_q;
        if (flush_in)     ex_d = '0;
        else if (hold_in) ex_d = ex_q;
        else if (haz)     ex_d = '0;
        else              ex_d = id_pkt;
    end

    always_ff @(posedge clk) begin
        if (rst) ex_q <= '0;
        else     ex_q <= ex_d;
    end

`ifdef ID_EX_PERF_EN
    logic [31:0] bubble_cnt_d, bubble_cnt_q;
    logic [31:0] flush_cnt_d,  flush_cnt_q;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (flush_in)                 flush_cnt_d  = flush_cnt_q + 32'd1;
        if (!flush_in && !hold_in && haz) bubble_cnt_d = bubble_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign flush_cnt  = flush_cnt_q;
`endif

    assign ex_valid      = ex_q.valid;
    assign ex_pc         = ex_q.pc;
    assign ex_rs1_data   = ex_q.rs1_data;
    assign ex_rs2_data   = ex_q.rs2_data;
    assign ex_imm        = ex_q.imm;
    assign ex_rs1        = ex_q.rs1;
    assign ex_rs2        = ex_q.rs2;
    assign ex_rd         = ex_q.rd;
    assign ex_uses_rs1   = ex_q.uses_rs1;
    assign ex_uses_rs2   = ex_q.uses_rs2;
    assign ex_alu_op     = ex_q.alu_op;
    assign ex_funct3     = ex_q.funct3;
    assign ex_funct7     = ex_q.funct7;
    assign ex_alu_src    = ex_q.alu_src;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_to_reg = ex_q.mem_to_reg;
    assign ex_branch     = ex_q.branch;

endmodule

// File: tb/tb_id_ex_reg.sv
// ----------------------------------------------------------------------------
// tb_id_ex_reg -- directed, self-checking bench for id_ex_reg.
// Inputs change 1 ns after the rising edge; registered outputs are observed
// there, and hazard_stall is observed 1 ns after the inputs settle.
// ----------------------------------------------------------------------------
module tb_id_ex_reg;

    logic        clk = 1'b0;
    logic        rst, hold_in, flush_in, id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_uses_rs1, id_uses_rs2;
    logic [1:0]  id_alu_op;
    logic [2:0]  id_funct3;
    logic [6:0]  id_funct7;
    logic        id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg, id_branch;

    logic        ex_valid;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic        ex_uses_rs1, ex_uses_rs2;
    logic [1:0]  ex_alu_op;
    logic [2:0]  ex_funct3;
    logic [6:0]  ex_funct7;
    logic        ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch;
    logic        hazard_stall;
`ifdef ID_EX_PERF_EN
    logic [31:0] bubble_cnt, flush_cnt;
`endif

    int vec  = 0;
    int errs = 0;

    always #5 clk = ~clk;

    id_ex_reg dut (
        .clk(clk), .rst(rst), .hold_in(hold_in), .flush_in(flush_in), .id_valid(id_valid),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_alu_op(id_alu_op), .id_funct3(id_funct3), .id_funct7(id_funct7),
        .id_alu_src(id_alu_src), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_uses_rs1(ex_uses_rs1), .ex_uses_rs2(ex_uses_rs2),
        .ex_alu_op(ex_alu_op), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
        .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch),
`ifdef ID_EX_PERF_EN
        .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt),
`endif
        .hazard_stall(hazard_stall)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Drive an ID instruction; mem_to_reg follows mem_read (loads write back memory data).
    task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                          input logic [1:0] op, input logic mr, input logic mw, input logic rw);
        id_valid = v;  id_pc = pc;  id_rd = rd;
        id_rs1 = rs1;  id_uses_rs1 = u1;  id_rs2 = rs2;  id_uses_rs2 = u2;
        id_alu_op = op; id_mem_read = mr; id_mem_write = mw; id_reg_write = rw;
        id_mem_to_reg = mr; id_alu_src = mr | mw; id_branch = 1'b0;
        id_rs1_data = pc ^ 32'hAAAA_0000; id_rs2_data = pc ^ 32'h0000_5555;
        id_imm = 32'h10; id_funct3 = 3'd0; id_funct7 = 7'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1; hold_in = 1'b0; flush_in = 1'b0;
        id_valid = 1'b1; id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom;
        id_imm = $urandom; id_rs1 = 5'($urandom); id_rs2 = 5'($urandom); id_rd = 5'($urandom);
        id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1; id_alu_op = 2'b10; id_funct3 = 3'd5; id_funct7 = 7'h20;
        id_alu_src = 1'b1; id_mem_read = 1'b1; id_mem_write = 1'b1; id_reg_write = 1'b1;
        id_mem_to_reg = 1'b1; id_branch = 1'b1;
        step(); step();
        vec++; if (ex_valid !== 1'b0) begin errs++; $display("FAIL rst_valid: got %0h want 0", ex_valid); end
        vec++; if (ex_pc !== 32'd0) begin errs++; $display("FAIL rst_pc: got %0h want 0", ex_pc); end
        vec++; if (ex_rd !== 5'd0) begin errs++; $display("FAIL rst_rd: got %0h want 0", ex_rd); end
        vec++; if (ex_alu_op !== 2'b00) begin errs++; $display("FAIL rst_alu_op: got %0h want 0", ex_alu_op); end
        vec++; if ({ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_mem_to_reg, ex_alu_src} !== 6'd0) begin
            errs++; $display("FAIL rst_ctrl: got %0h want 0", {ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_mem_to_reg, ex_alu_src}); end
        vec++; if ({ex_imm, ex_rs1_data, ex_funct7} !== '0) begin errs++; $display("FAIL rst_data: imm %0h rs1d %0h want 0", ex_imm, ex_rs1_data); end
        vec++; if (hazard_stall !== 1'b0) begin errs++; $display("FAIL rst_stall: got %0h want 0", hazard_stall); end
`ifdef ID_EX_PERF_EN
        vec++; if ({bubble_cnt, flush_cnt} !== 64'd0) begin errs++; $display("FAIL rst_cnt: got %0h/%0h want 0", bubble_cnt, flush_cnt); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_add();
        set_id(1'b1, 32'h100, 5'd5, 5'd1, 1'b1, 5'd2, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1);
        settle();
        vec++; if (hazard_stall !== 1'b0) begin errs++; $display("FAIL add_stall: got %0h want 0", hazard_stall); end
        step();
        vec++; if (ex_rd !== 5'd5) begin errs++; $display("FAIL add_rd: got %0h want 5", ex_rd); end
        vec++; if (ex_reg_write !== 1'b1) begin errs++; $display("FAIL add_rw: got %0h want 1", ex_reg_write); end
        vec++; if (ex_alu_op !== 2'b10) begin errs++; $display("FAIL add_op: got %0h want 2", ex_alu_op); end
        vec++; if (ex_valid !== 1'b1) begin errs++; $display("FAIL add_valid: got %0h want 1", ex_valid); end
        vec++; if (ex_pc !== 32'h100 || ex_rs2_data !== 32'h0000_5455) begin
            errs++; $display("FAIL add_data: pc %0h rs2d %0h want 100/5455", ex_pc, ex_rs2_data); end
    endtask

    task automatic test_load_use();
        set_id(1'b1, 32'h104, 5'd6, 5'd1, 1'b1, 5'd0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
        step();
        vec++; if (ex_mem_read !== 1'b1 || ex_rd !== 5'd6) begin errs++; $display("FAIL lu_load: mr %0h rd %0h want 1/6", ex_mem_read, ex_rd); end
        set_id(1'b1, 32'h108, 5'd7, 5'd3, 1'b1, 5'd6, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1);
        settle();
        vec++; if (hazard_stall !== 1'b1) begin errs++; $display("FAIL lu_stall: got %0h want 1", hazard_stall); end
        step();
        vec++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0 || ex_rd !== 5'd0) begin
            errs++; $display("FAIL lu_bubble: v %0h rw %0h mr %0h rd %0h want 0", ex_valid, ex_reg_write, ex_mem_read, ex_rd); end
        vec++; if (hazard_stall !== 1'b0) begin errs++; $display("FAIL lu_stall_drop: got %0h want 0", hazard_stall); end
`ifdef ID_EX_PERF_EN
        vec++; if (bubble_cnt !== 32'd1) begin errs++; $display("FAIL lu_bubble_cnt: got %0d want 1", bubble_cnt); end
`endif
        step();
        vec++; if (ex_valid !== 1'b1 || ex_rd !== 5'd7 || ex_pc !== 32'h108) begin
            errs++; $display("FAIL lu_dep: v %0h rd %0h pc %0h want 1/7/108", ex_valid, ex_rd, ex_pc); end
    endtask

    task automatic test_x0_load();
        set_id(1'b1, 32'h10C, 5'd0, 5'd1, 1'b1, 5'd0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
        step();
        set_id(1'b1, 32'h110, 5'd8, 5'd0, 1'b1, 5'd0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1);
        settle();
        vec++; if (hazard_stall !== 1'b0) begin errs++; $display("FAIL x0_stall: got %0h want 0", hazard_stall); end
        step();
        vec++; if (ex_valid !== 1'b1 || ex_rd !== 5'd8) begin errs++; $display("FAIL x0_load: v %0h rd %0h want 1/8", ex_valid, ex_rd); end
`ifdef ID_EX_PERF_EN
        vec++; if (bubble_cnt !== 32'd1) begin errs++; $display("FAIL x0_bubble_cnt: got %0d want 1", bubble_cnt); end
`endif
    endtask

    task automatic test_flush();
        set_id(1'b1, 32'h114, 5'd9, 5'd1, 1'b1, 5'd0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
        step();
        // store whose base register is the load result
        set_id(1'b1, 32'h118, 5'd0, 5'd9, 1'b1, 5'd2, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
        hold_in = 1'b1;
        settle();
        vec++; if (hazard_stall !== 1'b1) begin errs++; $display("FAIL fl_pre_stall: got %0h want 1", hazard_stall); end
        flush_in = 1'b1;
        settle();
        vec++; if (hazard_stall !== 1'b0) begin errs++; $display("FAIL fl_stall: got %0h want 0", hazard_stall); end
        step();
        vec++; if (ex_valid !== 1'b0 || ex_mem_write !== 1'b0 || ex_mem_read !== 1'b0 || ex_rd !== 5'd0) begin
            errs++; $display("FAIL fl_bubble: v %0h mw %0h mr %0h rd %0h want 0", ex_valid, ex_mem_write, ex_mem_read, ex_rd); end
`ifdef ID_EX_PERF_EN
        vec++; if (flush_cnt !== 32'd1 || bubble_cnt !== 32'd1) begin
            errs++; $display("FAIL fl_cnt: flush %0d bubble %0d want 1/1", flush_cnt, bubble_cnt); end
`endif
        flush_in = 1'b0; hold_in = 1'b0;
    endtask

    task automatic test_hold();
        set_id(1'b1, 32'h200, 5'd10, 5'd1, 1'b1, 5'd2, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1);
        step();
        hold_in = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            set_id(1'b1, 32'h200 + 32'(4 * i), 5'(10 + i), 5'd1, 1'b1, 5'd2, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
            step();
            vec++; if (ex_pc !== 32'h200 || ex_rd !== 5'd10 || ex_reg_write !== 1'b1 || ex_mem_write !== 1'b0) begin
                errs++; $display("FAIL hold_%0d: pc %0h rd %0h rw %0h mw %0h want 200/a/1/0", i, ex_pc, ex_rd, ex_reg_write, ex_mem_write); end
        end
        hold_in = 1'b0;
        set_id(1'b1, 32'h210, 5'd14, 5'd1, 1'b1, 5'd2, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1);
        step();
        vec++; if (ex_pc !== 32'h210 || ex_rd !== 5'd14 || ex_valid !== 1'b1) begin
            errs++; $display("FAIL hold_release: pc %0h rd %0h v %0h want 210/e/1", ex_pc, ex_rd, ex_valid); end
    endtask

    task automatic test_hold_haz();
        set_id(1'b1, 32'h300, 5'd4, 5'd1, 1'b1, 5'd0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
        step();
        set_id(1'b1, 32'h304, 5'd12, 5'd4, 1'b1, 5'd0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1);
        hold_in = 1'b1;
        step(); step();
        vec++; if (ex_mem_read !== 1'b1 || ex_rd !== 5'd4 || ex_valid !== 1'b1) begin
            errs++; $display("FAIL hh_hold: mr %0h rd %0h v %0h want 1/4/1", ex_mem_read, ex_rd, ex_valid); end
        vec++; if (hazard_stall !== 1'b1) begin errs++; $display("FAIL hh_stall: got %0h want 1", hazard_stall); end
`ifdef ID_EX_PERF_EN
        vec++; if (bubble_cnt !== 32'd1) begin errs++; $display("FAIL hh_cnt_hold: got %0d want 1", bubble_cnt); end
`endif
        hold_in = 1'b0;
        step();
        vec++; if (ex_valid !== 1'b0 || ex_rd !== 5'd0) begin errs++; $display("FAIL hh_bubble: v %0h rd %0h want 0/0", ex_valid, ex_rd); end
`ifdef ID_EX_PERF_EN
        vec++; if (bubble_cnt !== 32'd2) begin errs++; $display("FAIL hh_cnt: got %0d want 2", bubble_cnt); end
`endif
        step();
        vec++; if (ex_valid !== 1'b1 || ex_rd !== 5'd12) begin errs++; $display("FAIL hh_dep: v %0h rd %0h want 1/c", ex_valid, ex_rd); end
    endtask

    task automatic test_invalid();
        set_id(1'b0, 32'h400, 5'd15, 5'd1, 1'b1, 5'd2, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1);
        id_branch = 1'b1;
        step();
        vec++; if (ex_valid !== 1'b0 || {ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_mem_to_reg, ex_alu_src} !== 6'd0) begin
            errs++; $display("FAIL inv_ctrl: v %0h ctrl %0h want 0/0", ex_valid, {ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_mem_to_reg, ex_alu_src}); end
        vec++; if (ex_pc !== 32'h400 || ex_rd !== 5'd15) begin errs++; $display("FAIL inv_data: pc %0h rd %0h want 400/f", ex_pc, ex_rd); end
    endtask

    task automatic test_rst_mid_stall();
        set_id(1'b1, 32'h500, 5'd3, 5'd1, 1'b1, 5'd0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
        step();
        set_id(1'b1, 32'h504, 5'd13, 5'd0, 1'b0, 5'd3, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1);
        settle();
        vec++; if (hazard_stall !== 1'b1) begin errs++; $display("FAIL rs_stall_pre: got %0h want 1", hazard_stall); end
        rst = 1'b1;
        step();
        vec++; if (ex_valid !== 1'b0 || ex_rd !== 5'd0 || ex_mem_read !== 1'b0) begin
            errs++; $display("FAIL rs_clear: v %0h rd %0h mr %0h want 0", ex_valid, ex_rd, ex_mem_read); end
        vec++; if (hazard_stall !== 1'b0) begin errs++; $display("FAIL rs_stall: got %0h want 0", hazard_stall); end
`ifdef ID_EX_PERF_EN
        vec++; if ({bubble_cnt, flush_cnt} !== 64'd0) begin errs++; $display("FAIL rs_cnt: got %0h/%0h want 0", bubble_cnt, flush_cnt); end
`endif
        rst = 1'b0;
        step();
        vec++; if (ex_valid !== 1'b1 || ex_rd !== 5'd13) begin errs++; $display("FAIL rs_resume: v %0h rd %0h want 1/d", ex_valid, ex_rd); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_load_use();
        test_x0_load();
        test_flush();
        test_hold();
        test_hold_haz();
        test_invalid();
        test_rst_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
